patp_core_param: RTL
====================

# patp_core_param

Parametrised successor to the fixed 8-bit PATP core: a single-accumulator multi-cycle CPU with configurable data and address widths. Memory is external and reached through a req/ack handshake, which allows variable memory latency. The block adds a conditional-branch flag, an explicit halt state and debug observation ports. The control FSM, PC, IR, MDR, D0, Z flag and ALU are all internal.

## Interface
- DATA_W, 8: data/instruction width; must satisfy DATA_W - ADDR_W >= 3.
- ADDR_W, 5: address width; the PC and the instruction operand field are ADDR_W bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  DATA_W  write data (always D0).
- mem_rdata  in  DATA_W  read data; sampled on the completing edge.
- mem_ack  in  1  completes the transaction on any edge where mem_req && mem_ack; ignored when mem_req is low.
- halted  out  1  core is in HALTED.
- dbg_pc  out  ADDR_W  current PC.
- dbg_d0  out  DATA_W  current D0.
- dbg_z  out  1  current Z flag.

## Operation
- Instruction format:
  - OP = IR[DATA_W-1:ADDR_W] (OP_W = DATA_W - ADDR_W bits).
  - A = IR[ADDR_W-1:0].
- Opcodes:
  - 0 LOAD: D0 = M[A].
  - 1 STORE: M[A] = D0.
  - 2 ADD: D0 = D0 + M[A].
  - 3 SUB: D0 = D0 - M[A].
  - 4 JMP: PC = A.
  - 5 JZ: if Z, PC = A.
  - 6 AND: D0 = D0 & M[A].
  - 7 HALT.
  - OP >= 8 (only possible when OP_W > 3): NOP.
- Arithmetic is modulo 2^DATA_W; no carry or overflow is kept.
- Z = (new D0 == 0), updated only by LOAD, ADD, SUB and AND.
- PC increments modulo 2^ADDR_W, so all-ones wraps to 0.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
  - IDLE: no request. Always the next state is FETCH.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ack: IR = rdata, PC = PC+1, go to DECODE. Otherwise hold.
  - DECODE: JMP loads PC, go to FETCH. JZ loads PC if Z, go to FETCH. HALT goes to HALTED. NOP goes to FETCH. All other opcodes go to EXEC.
  - EXEC: mem_req=1, mem_addr=A, mem_we=(OP==STORE), mem_wdata=D0. On ack: STORE goes to FETCH; otherwise MDR = rdata and go to WB. Otherwise hold.
  - WB: D0 = ALU(D0, MDR); Z is updated; go to FETCH.
  - HALTED: no requests. Left only via rst.
- Outside FETCH and EXEC: mem_req=0. mem_addr and mem_we may be don't-care, but mem_req must never be X.

## Timing
- Reset, sampled on a rising edge with rst=1:
  - State goes to IDLE.
  - PC, IR, MDR, D0 = 0; Z = 0.
  - mem_req = 0, halted = 0.
- First fetch request appears in the cycle after rst falls.
- Reset mid-transaction aborts the transaction with no register update. The memory must drop any pending ack, since mem_req is low after the reset edge.
- Handshake rules:
  - Once raised, mem_req, mem_we, mem_addr and mem_wdata hold stable until the completing edge.
  - Zero-wait memory may assert ack combinationally in the same cycle as req.
  - Each cycle of ack delay adds one cycle to the state.
  - At most one outstanding transaction.
- Cycle counts with zero-wait memory:
  - LOAD/ADD/SUB/AND: 4 cycles.
  - STORE: 3 cycles.
  - JMP/JZ/NOP: 2 cycles.
  - HALT: halted rises 2 cycles after the fetch cycle begins.
- mem_req never stays high into DECODE or WB.
- Back-to-back requests are separated by at least one non-request cycle, except EXEC (STORE) → FETCH.
- dbg_* and halted are registered-state views with no combinational path from mem_*.

## Test plan
- Reset then fetch:
  - Stimulus: rst high for 3 cycles, then low; zero-wait memory.
  - Response: mem_req=0 during reset and in the first cycle after it; then mem_req=1 with mem_addr=0 and mem_we=0.
- Arithmetic and Z (DATA_W=8, ADDR_W=5):
  - Stimulus: program LOAD 20, ADD 21, SUB 22, HALT with M[20]=0x05, M[21]=0xFE, M[22]=0x03.
  - Response: D0=0x00 (wraps), dbg_z=1, halted=1; no requests after halt.
- Store and branch:
  - Stimulus: program LOAD 30, STORE 31, JZ 0, JMP 5, with HALT at address 5 and M[30]=0x00.
  - Response: M[31]=0x00 is written with mem_we=1 for exactly one ack; JZ taken, PC returns to 0.
  - Variant: with M[30]=0x07, JZ is not taken and the core halts at address 5.
- Variable latency:
  - Stimulus: random 0–5 cycle ack delay on every transaction.
  - Response: mem_addr, mem_we and mem_wdata are stable while mem_req is high; final D0, Z and PC match a reference model; acks while mem_req=0 have no effect.
- Parameter and wrap:
  - Stimulus: DATA_W=12, ADDR_W=8; program NOP (OP=8) at 0xFF, reached by JMP 0xFF.
  - Response: PC wraps 0xFF→0x00; the NOP leaves D0 and Z unchanged.
- Reset mid-EXEC:
  - Stimulus: assert rst while in EXEC of an ADD with ack withheld.
  - Response: D0 and PC = 0 and mem_req=0 on the next cycle; refetch from address 0 follows.

Source files
------------

// File: rtl/patp_core_param.sv
// Parametrised single-accumulator multi-cycle CPU; external memory via req/ack, each ack-wait cycle stretches the current state.
// LOAD/ADD/SUB/AND take 4 cycles, STORE 3, JMP/JZ/NOP 2 with zero-wait memory; request outputs hold until the completing edge.
module patp_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [DATA_W-1:0] dbg_d0,
  output logic              dbg_z
);

  localparam int OP_W = DATA_W - ADDR_W;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JZ    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] d0;
  logic              z;
  logic [DATA_W-1:0] alu_res;
  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] opa;

  assign op  = ir[DATA_W-1:ADDR_W];
  assign opa = ir[ADDR_W-1:0];

  always_comb begin
    alu_res = d0;
    case (op)
      OP_LOAD: alu_res = mdr;
      OP_ADD:  alu_res = d0 + mdr;
      OP_SUB:  alu_res = d0 - mdr;
      OP_AND:  alu_res = d0 & mdr;
      default: alu_res = d0;
    endcase
  end

  // Request outputs are registered alongside the state so they only change on
  // transitions into FETCH/EXEC and stay put while the memory stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      mdr      <= '0;
      d0       <= '0;
      z        <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
        end
        S_FETCH: begin
          if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc + ADDR_W'(1);
            state   <= S_DECODE;
            mem_req <= 1'b0;
          end
        end
        S_DECODE: begin
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
          case (op)
            OP_JMP: begin
              pc       <= opa;
              mem_addr <= opa;
            end
            OP_JZ: begin
              if (z) begin
                pc       <= opa;
                mem_addr <= opa;
              end
            end
            OP_HALT: begin
              state   <= S_HALTED;
              mem_req <= 1'b0;
              halted  <= 1'b1;
            end
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND: begin
              state    <= S_EXEC;
              mem_addr <= opa;
              mem_we   <= (op == OP_STORE);
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          if (mem_ack) begin
            if (op == OP_STORE) begin
              // The only back-to-back request: straight into the next fetch.
              state    <= S_FETCH;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end else begin
              mdr     <= mem_rdata;
              state   <= S_WB;
              mem_req <= 1'b0;
            end
          end
        end
        S_WB: begin
          d0       <= alu_res;
          z        <= (alu_res == '0);
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
        end
        S_HALTED: ;
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_wdata = d0;
  assign dbg_pc    = pc;
  assign dbg_d0    = d0;
  assign dbg_z     = z;

endmodule
